// File: rtl/decade_logger.sv
// Wrap logger for a 0..WRAP_VAL up-counter: BCD wrap total, legality checking,
// and a small FIFO of timestamped per-wrap records drained over valid/ready.
module decade_logger #(
   parameter int CNT_W      = 8,
   parameter int WRAP_VAL   = 10,
   parameter int NDIGITS    = 3,
   parameter int TS_W       = 16,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                   decade_logger_clk,
   input  logic                   decade_logger_reset,
   input  logic [CNT_W-1:0]       decade_logger_cnt_in,
   input  logic                   decade_logger_en,
   input  logic                   decade_logger_clr,
   output logic [4*NDIGITS-1:0]   decade_logger_total_bcd,
   output logic                   decade_logger_rec_valid,
   input  logic                   decade_logger_rec_ready,
   output logic [4*NDIGITS-1:0]   decade_logger_rec_bcd,
   output logic [TS_W-1:0]        decade_logger_rec_ts,
   output logic                   decade_logger_ovf,
   output logic                   decade_logger_bcd_wrap,
   output logic                   decade_logger_err
);

   localparam int BW = 4 * NDIGITS;
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam logic [CNT_W-1:0] WRAP_V = CNT_W'(WRAP_VAL);
   localparam logic [AW:0]      FULL_V = (AW+1)'(FIFO_DEPTH);

   logic [CNT_W-1:0] r_prev;
   logic             r_primed;
   logic [TS_W-1:0]  r_ts;
   logic [BW-1:0]    r_total;
   logic             r_ovf;
   logic             r_bcd_wrap;
   logic             r_err;
   logic [BW-1:0]    r_mem_bcd [FIFO_DEPTH];
   logic [TS_W-1:0]  r_mem_ts  [FIFO_DEPTH];
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [AW:0]      r_occ;

   logic          w_active;
   logic          w_wrap_evt;
   logic          w_step_ok;
   logic          w_step_bad;
   logic [BW-1:0] w_total_inc;
   logic          w_all9;
   logic          w_push;
   logic          w_pop;
   logic          w_full;
   logic          w_do_push;

   assign w_active   = decade_logger_en & r_primed;
   assign w_wrap_evt = w_active & (r_prev == WRAP_V) & (decade_logger_cnt_in == '0);
   // widened compare so prev+1 cannot alias to 0 at the top of the range
   assign w_step_ok  = ({1'b0, decade_logger_cnt_in} == {1'b0, r_prev}) |
                       ({1'b0, decade_logger_cnt_in} == ({1'b0, r_prev} + (CNT_W+1)'(1)));
   assign w_step_bad = w_active & ~w_wrap_evt &
                       ((decade_logger_cnt_in > WRAP_V) | ~w_step_ok);

   always_comb begin : bcd_inc
      logic v_carry;
      w_total_inc = r_total;
      v_carry     = 1'b1;
      for (int i = 0; i < NDIGITS; i++) begin
         if (v_carry) begin
            if (r_total[4*i +: 4] == 4'd9) begin
               w_total_inc[4*i +: 4] = 4'd0;
            end else begin
               w_total_inc[4*i +: 4] = r_total[4*i +: 4] + 4'd1;
               v_carry = 1'b0;
            end
         end
      end
      w_all9 = v_carry;
   end

   assign w_push    = w_wrap_evt & ~decade_logger_clr;
   assign w_full    = (r_occ == FULL_V);
   assign w_pop     = (r_occ != '0) & decade_logger_rec_ready;
   assign w_do_push = w_push & (~w_full | w_pop);

   always_ff @(posedge decade_logger_clk or negedge decade_logger_reset) begin
      if (!decade_logger_reset) begin
         r_prev     <= '0;
         r_primed   <= 1'b0;
         r_ts       <= '0;
         r_total    <= '0;
         r_ovf      <= 1'b0;
         r_bcd_wrap <= 1'b0;
         r_err      <= 1'b0;
      end else begin
         r_prev   <= decade_logger_cnt_in;
         r_primed <= decade_logger_en & ~decade_logger_clr;
         if (decade_logger_clr) begin
            r_ts       <= '0;
            r_total    <= '0;
            r_ovf      <= 1'b0;
            r_bcd_wrap <= 1'b0;
            r_err      <= 1'b0;
         end else begin
            r_ts <= r_ts + TS_W'(1);
            if (w_wrap_evt) begin
               r_total <= w_total_inc;
               if (w_all9) r_bcd_wrap <= 1'b1;
            end
            if (w_step_bad) r_err <= 1'b1;
            if (w_push & w_full & ~w_pop) r_ovf <= 1'b1;
         end
      end
   end

   always_ff @(posedge decade_logger_clk or negedge decade_logger_reset) begin
      if (!decade_logger_reset) begin
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            r_mem_bcd[i] <= '0;
            r_mem_ts[i]  <= '0;
         end
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_occ    <= '0;
      end else begin
         if (w_do_push) begin
            r_mem_bcd[r_wr_ptr] <= w_total_inc;
            r_mem_ts[r_wr_ptr]  <= r_ts;
            r_wr_ptr            <= r_wr_ptr + AW'(1);
         end
         if (w_pop) r_rd_ptr <= r_rd_ptr + AW'(1);
         if (w_do_push & ~w_pop)      r_occ <= r_occ + (AW+1)'(1);
         else if (~w_do_push & w_pop) r_occ <= r_occ - (AW+1)'(1);
      end
   end

   assign decade_logger_total_bcd = r_total;
   assign decade_logger_rec_valid = (r_occ != '0);
   assign decade_logger_rec_bcd   = (r_occ != '0) ? r_mem_bcd[r_rd_ptr] : '0;
   assign decade_logger_rec_ts    = (r_occ != '0) ? r_mem_ts[r_rd_ptr]  : '0;
   assign decade_logger_ovf       = r_ovf;
   assign decade_logger_bcd_wrap  = r_bcd_wrap;
   assign decade_logger_err       = r_err;

endmodule

// File: tb/tb_decade_logger.sv
// Directed bench for decade_logger: step-check vector table plus sequences for
// FIFO fill/overflow, BCD rollover, clear priority and asynchronous reset.
module tb_decade_logger;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [7:0]  cnt = 8'd0;
   logic        en = 1'b0;
   logic        clr = 1'b0;
   logic        ready = 1'b0;
   logic [11:0] total_bcd;
   logic        rec_valid;
   logic [11:0] rec_bcd;
   logic [15:0] rec_ts;
   logic        ovf;
   logic        bcd_wrap;
   logic        err;

   int checks = 0;
   int errors = 0;

   logic [11:0] q_bcd[$];
   logic [15:0] q_ts[$];

   typedef struct {
      logic [7:0]  cnt;
      logic        en;
      logic        clr;
      logic        exp_err;
      logic [11:0] exp_total;
   } vec_t;

   vec_t tv[18];

   decade_logger dut (
      .decade_logger_clk       (clk),
      .decade_logger_reset     (rst_n),
      .decade_logger_cnt_in    (cnt),
      .decade_logger_en        (en),
      .decade_logger_clr       (clr),
      .decade_logger_total_bcd (total_bcd),
      .decade_logger_rec_valid (rec_valid),
      .decade_logger_rec_ready (ready),
      .decade_logger_rec_bcd   (rec_bcd),
      .decade_logger_rec_ts    (rec_ts),
      .decade_logger_ovf       (ovf),
      .decade_logger_bcd_wrap  (bcd_wrap),
      .decade_logger_err       (err)
   );

   always #5 clk = ~clk;

   function automatic vec_t mk(input logic [7:0] c, input logic e, input logic cl,
                               input logic er, input logic [11:0] t);
      vec_t v;
      v.cnt = c; v.en = e; v.clr = cl; v.exp_err = er; v.exp_total = t;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   // Records handed over this cycle are captured before the edge that pops them.
   task automatic tick();
      if (rec_valid && ready) begin
         q_bcd.push_back(rec_bcd);
         q_ts.push_back(rec_ts);
      end
      @(posedge clk);
      #1;
   endtask

   // Expects the previous sample to be 0; the final 10 -> 0 step is a wrap.
   task automatic count_cycle();
      for (int v = 1; v <= 10; v++) begin
         cnt = 8'(v);
         tick();
      end
      cnt = 8'd0;
      tick();
   endtask

   initial begin
      tv[0]  = mk(8'd0,  1'b1, 1'b0, 1'b0, 12'h000);
      tv[1]  = mk(8'd1,  1'b1, 1'b0, 1'b0, 12'h000);
      tv[2]  = mk(8'd1,  1'b1, 1'b0, 1'b0, 12'h000);
      tv[3]  = mk(8'd2,  1'b1, 1'b0, 1'b0, 12'h000);
      tv[4]  = mk(8'd3,  1'b1, 1'b0, 1'b0, 12'h000);
      tv[5]  = mk(8'd7,  1'b1, 1'b0, 1'b1, 12'h000);
      tv[6]  = mk(8'd8,  1'b1, 1'b0, 1'b1, 12'h000);
      tv[7]  = mk(8'd9,  1'b1, 1'b0, 1'b1, 12'h000);
      tv[8]  = mk(8'd10, 1'b1, 1'b0, 1'b1, 12'h000);
      tv[9]  = mk(8'd0,  1'b1, 1'b0, 1'b1, 12'h001);
      tv[10] = mk(8'd12, 1'b1, 1'b0, 1'b1, 12'h001);
      tv[11] = mk(8'd0,  1'b1, 1'b0, 1'b1, 12'h001);
      tv[12] = mk(8'd0,  1'b1, 1'b1, 1'b0, 12'h000);
      tv[13] = mk(8'd1,  1'b0, 1'b0, 1'b0, 12'h000);
      tv[14] = mk(8'd9,  1'b0, 1'b0, 1'b0, 12'h000);
      tv[15] = mk(8'd10, 1'b1, 1'b0, 1'b0, 12'h000);
      tv[16] = mk(8'd0,  1'b1, 1'b0, 1'b0, 12'h001);
      tv[17] = mk(8'd5,  1'b1, 1'b0, 1'b1, 12'h001);

      #2;
      chk("reset_total", total_bcd, 12'h000);
      chk("reset_valid", rec_valid, 1'b0);
      chk("reset_rec_bcd", rec_bcd, 12'h000);
      chk("reset_rec_ts", rec_ts, 16'h0000);
      chk("reset_flags", {ovf, bcd_wrap, err}, 3'b000);
      #20;
      rst_n = 1'b1;
      @(posedge clk); #1;

      // 1: three wraps with the consumer ready
      en = 1'b1; ready = 1'b1; cnt = 8'd0;
      tick();
      for (int v = 1; v <= 10; v++) begin
         cnt = 8'(v);
         tick();
      end
      chk("t1_pre_total", total_bcd, 12'h000);
      chk("t1_pre_valid", rec_valid, 1'b0);
      cnt = 8'd0;
      tick();
      chk("t1_first_total", total_bcd, 12'h001);
      chk("t1_first_valid", rec_valid, 1'b1);
      chk("t1_first_bcd", rec_bcd, 12'h001);
      count_cycle();
      count_cycle();
      tick();
      chk("t1_total", total_bcd, 12'h003);
      chk("t1_nrec", q_bcd.size(), 3);
      chk("t1_rec0", q_bcd[0], 12'h001);
      chk("t1_rec1", q_bcd[1], 12'h002);
      chk("t1_rec2", q_bcd[2], 12'h003);
      chk("t1_dt1", 16'(q_ts[1] - q_ts[0]), 16'd11);
      chk("t1_dt2", 16'(q_ts[2] - q_ts[1]), 16'd11);
      chk("t1_valid_drained", rec_valid, 1'b0);

      // 2: consumer stalled, six wraps into a 4-deep FIFO
      ready = 1'b0; clr = 1'b1;
      tick();
      clr = 1'b0;
      q_bcd.delete(); q_ts.delete();
      for (int w = 1; w <= 6; w++) begin
         count_cycle();
         chk($sformatf("t2_ovf_w%0d", w), ovf, (w >= 5) ? 1'b1 : 1'b0);
      end
      chk("t2_total", total_bcd, 12'h006);
      chk("t2_head_held", rec_bcd, 12'h001);
      ready = 1'b1;
      for (int i = 0; i < 5; i++) tick();
      chk("t2_nrec", q_bcd.size(), 4);
      for (int i = 0; i < 4; i++) chk($sformatf("t2_rec%0d", i), q_bcd[i], 12'(i + 1));
      chk("t2_empty", rec_valid, 1'b0);

      // 3: BCD rollover from 999
      clr = 1'b1;
      tick();
      clr = 1'b0;
      chk("t3_clr_ovf", ovf, 1'b0);
      for (int w = 0; w < 999; w++) count_cycle();
      chk("t3_total_999", total_bcd, 12'h999);
      chk("t3_no_bcd_wrap", bcd_wrap, 1'b0);
      q_bcd.delete(); q_ts.delete();
      count_cycle();
      chk("t3_total_0", total_bcd, 12'h000);
      chk("t3_bcd_wrap", bcd_wrap, 1'b1);
      tick();
      chk("t3_nrec", q_bcd.size(), 2);
      chk("t3_rec_999", q_bcd[0], 12'h999);
      chk("t3_rec_000", q_bcd[1], 12'h000);
      chk("t3_ovf", ovf, 1'b0);

      // 4: step-check vector table
      clr = 1'b1;
      tick();
      clr = 1'b0;
      chk("t4_clr_bcd_wrap", bcd_wrap, 1'b0);
      for (int i = 0; i < 18; i++) begin
         cnt = tv[i].cnt; en = tv[i].en; clr = tv[i].clr;
         tick();
         chk($sformatf("t4_err_%0d", i), err, tv[i].exp_err);
         chk($sformatf("t4_total_%0d", i), total_bcd, tv[i].exp_total);
      end
      clr = 1'b0; en = 1'b1; cnt = 8'd0;

      // 5: clear in the wrap cycle discards the event, keeps the FIFO
      ready = 1'b0; clr = 1'b1;
      tick();
      clr = 1'b0;
      tick();
      q_bcd.delete(); q_ts.delete();
      count_cycle();
      chk("t5_total_1", total_bcd, 12'h001);
      for (int v = 1; v <= 10; v++) begin
         cnt = 8'(v);
         tick();
      end
      cnt = 8'd0; clr = 1'b1;
      tick();
      clr = 1'b0;
      chk("t5_total_0", total_bcd, 12'h000);
      chk("t5_head", rec_bcd, 12'h001);
      ready = 1'b1;
      tick();
      ready = 1'b0;
      chk("t5_empty", rec_valid, 1'b0);
      chk("t5_nrec", q_bcd.size(), 1);

      // 6: full FIFO with simultaneous push and pop
      clr = 1'b1;
      tick();
      clr = 1'b0;
      q_bcd.delete(); q_ts.delete();
      for (int w = 0; w < 4; w++) count_cycle();
      chk("t6_full_ovf", ovf, 1'b0);
      for (int v = 1; v <= 10; v++) begin
         cnt = 8'(v);
         tick();
      end
      cnt = 8'd0; ready = 1'b1;
      tick();
      ready = 1'b0;
      chk("t6_ovf", ovf, 1'b0);
      chk("t6_total", total_bcd, 12'h005);
      chk("t6_head", rec_bcd, 12'h002);
      ready = 1'b1;
      for (int i = 0; i < 4; i++) tick();
      chk("t6_empty", rec_valid, 1'b0);
      chk("t6_nrec", q_bcd.size(), 5);
      for (int i = 0; i < 5; i++) chk($sformatf("t6_rec%0d", i), q_bcd[i], 12'(i + 1));

      // asynchronous reset with a record pending
      ready = 1'b0;
      count_cycle();
      chk("rst_pre_valid", rec_valid, 1'b1);
      #1;
      rst_n = 1'b0;
      #1;
      chk("rst_valid", rec_valid, 1'b0);
      chk("rst_total", total_bcd, 12'h000);
      chk("rst_rec_bcd", rec_bcd, 12'h000);
      chk("rst_rec_ts", rec_ts, 16'h0000);
      chk("rst_flags", {ovf, bcd_wrap, err}, 3'b000);
      #3;
      rst_n = 1'b1;
      tick();
      chk("post_rst_valid", rec_valid, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
